// File: rtl/maoin_led_pwm_pio.sv
// Avalon-MM LED output PIO: DATA with atomic set/clear, per-bit blink, and a
// global brightness PWM built only when LED_PWM_EN is defined.
module maoin_led_pwm_pio #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 50000,
   parameter int PWM_BITS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam int PS_W = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic             w_wr;
   logic [WIDTH-1:0] w_wd;
   logic             w_tick;
   logic             w_pwm_on;
   logic             w_unused_wd;

   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_mask;
   logic [15:0]      r_blink_div;
   logic [15:0]      r_blink_cnt;
   logic             r_phase;
   logic [PS_W-1:0]  r_ps_cnt;
   logic [WIDTH-1:0] r_out;

   assign w_wr        = chipselect && !write_n;
   assign w_wd        = writedata[WIDTH-1:0];
   assign w_tick      = (r_ps_cnt == PS_MAX);
   assign w_unused_wd = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= '0;
         r_mask <= '0;
      end else if (w_wr) begin
         case (address)
            3'd0: r_data <= w_wd;
            3'd1: r_data <= r_data | w_wd;
            3'd2: r_data <= r_data & ~w_wd;
            3'd3: r_mask <= w_wd;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ps_cnt <= '0;
      else          r_ps_cnt <= w_tick ? '0 : r_ps_cnt + 1'b1;
   end

   // A BLINK_DIV write restarts the blink from the lit phase and takes
   // priority over a toggle landing on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_div <= '0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (w_wr && address == 3'd4) begin
         r_blink_div <= writedata[15:0];
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_blink_div == 16'd0) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (w_tick) begin
         if (r_blink_cnt == r_blink_div - 16'd1) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 16'd1;
         end
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] r_duty;
   logic [PWM_BITS-1:0] r_pwm_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_duty    <= '1;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (w_wr && address == 3'd5) r_duty <= writedata[PWM_BITS-1:0];
      end
   end

   // All-ones duty means fully on, not 2^N-1 out of 2^N.
   assign w_pwm_on = (r_pwm_cnt < r_duty) || (&r_duty);
`else
   assign w_pwm_on = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_out <= '0;
      else          r_out <= r_data & (~r_mask | {WIDTH{r_phase}}) & {WIDTH{w_pwm_on}};
   end

   assign out_port = r_out;

   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0: readdata = 32'(r_data);
         3'd3: readdata = 32'(r_mask);
         3'd4: readdata = {16'd0, r_blink_div};
`ifdef LED_PWM_EN
         3'd5: readdata = 32'(r_duty);
`endif
         3'd6: readdata = {31'd0, r_phase};
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_maoin_led_pwm_pio.sv
// Directed self-checking bench for maoin_led_pwm_pio (WIDTH=8, PRESCALE=4,
// PWM_BITS=8); PWM expectations follow whether LED_PWM_EN is defined.
module tb_maoin_led_pwm_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int errs   = 0;

   maoin_led_pwm_pio #(.WIDTH(8), .PRESCALE(4), .PWM_BITS(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   // Counts cycles over one 256-cycle PWM period where out_port is lit / not a legal value.
   task automatic pwm_window(input logic [7:0] lit, output int on_cnt, output int bad_cnt);
      on_cnt = 0; bad_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (out_port !== 8'h00) on_cnt++;
         if (out_port !== 8'h00 && out_port !== lit) bad_cnt++;
      end
   endtask

   initial begin
      int n;
      int on_cnt;
      int bad_cnt;
      logic [31:0] exp_duty_rst;
`ifdef LED_PWM_EN
      exp_duty_rst = 32'hFF;
`else
      exp_duty_rst = 32'h0;
`endif
      reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
      repeat (3) @(negedge clk);

      chk("rst_out", {24'd0, out_port}, 32'h0);
      rd_chk("rst_rd0", 3'd0, 32'h0);
      rd_chk("rst_rd3", 3'd3, 32'h0);
      rd_chk("rst_rd4", 3'd4, 32'h0);
      rd_chk("rst_rd5", 3'd5, exp_duty_rst);
      rd_chk("rst_rd6", 3'd6, 32'h1);
      @(negedge clk);
      reset_n = 1'b1;

      // set / clear
      wr(3'd0, 32'h0F);
      wr(3'd1, 32'hA0);
      wr(3'd2, 32'h03);
      rd_chk("sc_rd0", 3'd0, 32'hAC);
      chk("sc_out_latency", {24'd0, out_port}, 32'hAF);
      @(negedge clk);
      chk("sc_out", {24'd0, out_port}, 32'hAC);
      rd_chk("sc_rd1", 3'd1, 32'h0);
      rd_chk("sc_rd2", 3'd2, 32'h0);

      // unused data bits
      wr(3'd0, 32'hFFFFFF00);
      rd_chk("hi_bits_rd0", 3'd0, 32'h0);

      // blink: DATA=FF, MASK=0F, DIV=2 -> 8 cycles F0, 8 cycles FF
      wr(3'd0, 32'hFF);
      wr(3'd3, 32'h0F);
      wr(3'd4, 32'h2);
      rd_chk("blink_rd4", 3'd4, 32'h2);
      rd_chk("blink_rd3", 3'd3, 32'h0F);
      address = 3'd6;
      n = 0;
      while (out_port !== 8'hF0 && n < 40) begin @(negedge clk); n++; end
      chk("blink_lo_val", {24'd0, out_port}, 32'hF0);
      #1 chk("blink_status0", readdata, 32'h0);
      n = 0;
      while (out_port === 8'hF0 && n < 40) begin @(negedge clk); n++; end
      chk("blink_lo_len", n, 32'd8);
      chk("blink_hi_val", {24'd0, out_port}, 32'hFF);
      n = 0;
      while (out_port === 8'hFF && n < 40) begin @(negedge clk); n++; end
      chk("blink_hi_len", n, 32'd8);

      wr(3'd4, 32'h0);
      @(negedge clk);
      bad_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_port !== 8'hFF) bad_cnt++;
      end
      chk("blink_div0_steady", bad_cnt, 32'd0);

      // asynchronous reset in the middle of blinking
      wr(3'd4, 32'h2);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk("mid_rst_out", {24'd0, out_port}, 32'h0);
      rd_chk("mid_rst_rd0", 3'd0, 32'h0);
      rd_chk("mid_rst_rd5", 3'd5, exp_duty_rst);
      rd_chk("mid_rst_rd6", 3'd6, 32'h1);
      @(negedge clk);
      reset_n = 1'b1;

      // address 7 ignored
      wr(3'd0, 32'h3C);
      wr(3'd7, 32'h55);
      rd_chk("a7_rd0", 3'd0, 32'h3C);
      rd_chk("a7_rd7", 3'd7, 32'h0);
      rd_chk("a7_rd3", 3'd3, 32'h0);

      wr(3'd0, 32'hAC);
`ifdef LED_PWM_EN
      wr(3'd5, 32'h40);
      rd_chk("pwm_rd5", 3'd5, 32'h40);
      repeat (2) @(negedge clk);
      pwm_window(8'hAC, on_cnt, bad_cnt);
      chk("pwm40_on", on_cnt, 32'd64);
      chk("pwm40_val", bad_cnt, 32'd0);
      wr(3'd5, 32'h0);
      repeat (2) @(negedge clk);
      pwm_window(8'hAC, on_cnt, bad_cnt);
      chk("pwm00_on", on_cnt, 32'd0);
      wr(3'd5, 32'hFF);
      repeat (2) @(negedge clk);
      pwm_window(8'hAC, on_cnt, bad_cnt);
      chk("pwmFF_on", on_cnt, 32'd256);
      chk("pwmFF_val", bad_cnt, 32'd0);
`else
      wr(3'd5, 32'h10);
      rd_chk("nopwm_rd5", 3'd5, 32'h0);
      repeat (2) @(negedge clk);
      bad_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (out_port !== 8'hAC) bad_cnt++;
      end
      chk("nopwm_out_steady", bad_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
